// File: rtl/sr_pulse_conditioner.sv
//------------------------------------------------------------------------------
// sr_pulse_conditioner
//
// Front end for a NOR SR latch. Two raw asynchronous pad inputs (set, reset)
// are synchronised and debounced. Each accepted rising edge becomes a clean,
// fixed-width pulse. The two pulse outputs are never high together, so the
// latch never sees S=R=1.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   set_raw      in   raw set request, asynchronous to clk
//   reset_raw    in   raw reset request, asynchronous to clk
//   set_pulse    out  registered set pulse, drives latch S (io_in[0])
//   reset_pulse  out  registered reset pulse, drives latch R (io_in[1])
//   conflict     out  one-cycle flag: set and reset edges accepted together
//   conflict_cnt out  [7:0] saturating count of conflict events; present only
//                     when SR_COND_CONFLICT_CNT_EN is defined
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept
//                    a new level (>=1)
//   PULSE_LEN        output pulse width in clk cycles (>=1)
//
// Optional feature macro: SR_COND_CONFLICT_CNT_EN
//
// Latency: a clean raw 0->1 transition reaches the pulse output
// DEBOUNCE_CYCLES+3 rising edges later. That is 2 synchroniser edges,
// DEBOUNCE_CYCLES debounce edges and 1 FSM edge.
//------------------------------------------------------------------------------
module sr_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_raw,
  input  logic       reset_raw,
  output logic       set_pulse,
  output logic       reset_pulse,
`ifdef SR_COND_CONFLICT_CNT_EN
  output logic       conflict,
  output logic [7:0] conflict_cnt
`else
  output logic       conflict
`endif
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PLS_LAST = PCNT_W'(PULSE_LEN - 1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_raw;
  logic [1:0] w_req;

  assign w_raw = {reset_raw, set_raw};

  //----------------------------------------------------------------------------
  // Per-channel synchroniser, debouncer and rising-edge detector
  //----------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic             r_sync1;
      logic             r_syn;
      logic             r_deb;
      logic             r_deb_d;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b0;
          r_syn   <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_syn   <= r_sync1;
          r_deb_d <= r_deb;
          // r_cnt counts consecutive samples that disagree with the
          // accepted level. The DEBOUNCE_CYCLES-th disagreeing sample
          // commits the new level. Any agreeing sample restarts the count.
          if (r_syn == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_deb <= r_syn;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      // Only the 0->1 transition of the debounced level is a request.
      // Falling edges are ignored.
      assign w_req[gi] = r_deb & ~r_deb_d;
    end
  endgenerate

  //----------------------------------------------------------------------------
  // Pulse FSM
  //----------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SET_P = 2'd1,
    S_RST_P = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [PCNT_W-1:0]   w_pcnt_next;
  logic                w_conflict_next;
  logic                r_set_pulse;
  logic                r_reset_pulse;
  logic                r_conflict;

  always_comb begin
    w_state_next    = r_state;
    w_pcnt_next     = r_pcnt;
    w_conflict_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pcnt_next = '0;
        if (w_req[0] && w_req[1]) begin
          // The two edges arrive together: flag the event and issue no pulse.
          w_conflict_next = 1'b1;
        end else if (w_req[0]) begin
          w_state_next = S_SET_P;
        end else if (w_req[1]) begin
          w_state_next = S_RST_P;
        end
      end

      S_SET_P: begin
        if (w_req[1]) begin
          // A reset aborts the set pulse and starts a full reset pulse.
          // A new set request here is dropped; it does not extend the pulse.
          w_state_next = S_RST_P;
          w_pcnt_next  = '0;
        end else if (r_pcnt == PLS_LEN_LAST()) begin
          w_state_next = S_IDLE;
          w_pcnt_next  = '0;
        end else begin
          w_pcnt_next  = r_pcnt + PCNT_W'(1);
        end
      end

      S_RST_P: begin
        // A reset pulse runs to completion. All requests are dropped.
        if (r_pcnt == PLS_LEN_LAST()) begin
          w_state_next = S_IDLE;
          w_pcnt_next  = '0;
        end else begin
          w_pcnt_next  = r_pcnt + PCNT_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_pcnt_next  = '0;
      end
    endcase
  end

  function automatic logic [PCNT_W-1:0] PLS_LEN_LAST();
    return PLS_LAST;
  endfunction

  // The outputs are registered copies of the next state. They therefore
  // rise on the same edge the FSM enters a pulse state, and they come
  // straight from flops with no decode glitches toward the latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pcnt        <= '0;
      r_set_pulse   <= 1'b0;
      r_reset_pulse <= 1'b0;
      r_conflict    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pcnt        <= w_pcnt_next;
      r_set_pulse   <= (w_state_next == S_SET_P);
      r_reset_pulse <= (w_state_next == S_RST_P);
      r_conflict    <= w_conflict_next;
    end
  end

  assign set_pulse   = r_set_pulse;
  assign reset_pulse = r_reset_pulse;
  assign conflict    = r_conflict;

`ifdef SR_COND_CONFLICT_CNT_EN
  //----------------------------------------------------------------------------
  // Saturating conflict event counter. Only rst_n clears it.
  //----------------------------------------------------------------------------
  logic [7:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 8'h00;
    end else if (w_conflict_next && (r_conflict_cnt != 8'hFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'h01;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
